// File: rtl/radix_digit_extractor_pkg.sv
// Shared types and constants for the radix digit extractor.
package radix_digit_extractor_pkg;

    localparam int DATA_W         = 8;
    localparam int DIGIT_W        = 4;
    localparam int DEFAULT_RADIX  = 10;
    localparam int DEFAULT_DIGITS = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DIVIDE = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

endpackage

// File: rtl/radix_digit_extractor.sv
// Converts an 8-bit unsigned value into DIGITS radix-RADIX digits, least
// significant first, by issuing one divide per clock to an external
// combinational divider wired to the div_* ports.
// Optional build macro RADIX_DIGIT_EXTRACTOR_EARLY_EXIT_EN: stop dividing as
// soon as the quotient reaches zero (digit values are unchanged, only the
// latency shortens).
module radix_digit_extractor
    import radix_digit_extractor_pkg::*;
#(
    parameter int RADIX  = DEFAULT_RADIX,
    parameter int DIGITS = DEFAULT_DIGITS
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [DATA_W-1:0]           in_value,
    output logic [DATA_W-1:0]           div_dividend,
    output logic [DATA_W-1:0]           div_divisor,
    input  logic [DATA_W-1:0]           div_quotient,
    input  logic [DATA_W-1:0]           div_remainder,
    input  logic                        div_by_zero,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DIGIT_W*DIGITS-1:0]   digits,
    output logic                        overflow,
    output logic                        error
);

    localparam int CNT_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIGITS - 1);

    state_e                       state_q, state_d;
    logic [DATA_W-1:0]            work_q, work_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic [DIGIT_W*DIGITS-1:0]    digits_q, digits_d;
    logic                         overflow_q, overflow_d;
    logic                         error_q, error_d;

    // Remainder is always below RADIX (at most 16), so its upper bits carry nothing.
    logic unused_rem_hi;
    assign unused_rem_hi = ^div_remainder[DATA_W-1:DIGIT_W];

    // Handshake flags and divider operands follow the registered state directly.
    assign in_ready     = (state_q == ST_IDLE);
    assign out_valid    = (state_q == ST_DONE);
    assign div_dividend = work_q;
    assign div_divisor  = DATA_W'(RADIX);
    assign digits       = digits_q;
    assign overflow     = overflow_q;
    assign error        = error_q;

    // Next-state logic: accept, one divide step per cycle, hold result until taken.
    always_comb begin
        // NOTE: every _d gets a hold default first, so no path leaves one unassigned and no latch is inferred.
        state_d    = state_q;
        work_d     = work_q;
        count_d    = count_q;
        digits_d   = digits_q;
        overflow_d = overflow_q;
        error_d    = error_q;

        // NOTE: combinational logic uses blocking '=' so later lines see earlier updates; flops use '<='.
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    work_d     = in_value;
                    count_d    = '0;
                    digits_d   = '0;
                    overflow_d = 1'b0;
                    error_d    = 1'b0;
                    state_d    = ST_DIVIDE;
                end
            end

            ST_DIVIDE: begin
                if (div_by_zero) begin
                    error_d    = 1'b1;
                    digits_d   = '0;
                    overflow_d = 1'b0;
                    state_d    = ST_DONE;
                end else begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (count_q == CNT_W'(i)) begin
                            digits_d[i*DIGIT_W +: DIGIT_W] = div_remainder[DIGIT_W-1:0];
                        end
                    end
                    work_d = div_quotient;
                    if (count_q == LAST_CNT) begin
                        // Counter parks on the last index rather than wrapping.
                        overflow_d = (div_quotient != '0);
                        state_d    = ST_DONE;
                    end else begin
                        count_d = count_q + 1'b1;
`ifdef RADIX_DIGIT_EXTRACTOR_EARLY_EXIT_EN
                        // Nothing left to divide: remaining digits are already zero.
                        if (div_quotient == '0) begin
                            state_d = ST_DONE;
                        end
`endif
                    end
                end
            end

            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // State register with synchronous reset that discards any conversion in flight.
    always_ff @(posedge clk) begin
        // NOTE: the digit file is a handful of flops, so it is reset with everything else.
        if (rst) begin
            state_q    <= ST_IDLE;
            work_q     <= '0;
            count_q    <= '0;
            digits_q   <= '0;
            overflow_q <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            work_q     <= work_d;
            count_q    <= count_d;
            digits_q   <= digits_d;
            overflow_q <= overflow_d;
            error_q    <= error_d;
        end
    end

endmodule

// File: tb/tb_radix_digit_extractor.sv
// Directed bench for radix_digit_extractor: three instances (10/3, 10/2, 2/8),
// each paired with a behavioural divider. Inputs change and outputs are
// sampled on the falling edge.
module tb_radix_digit_extractor;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]       in_valid, in_ready, out_valid, out_ready, ovf, err, dbz, force_dbz;
    logic [2:0][7:0]  in_value, dvd, dvs, quot, rem;
    logic [11:0]      dg_a;
    logic [7:0]       dg_b;
    logic [31:0]      dg_c;

    int total = 0;
    int bad   = 0;

    // Behavioural divider for each instance.
    always_comb begin
        quot = '0;
        rem  = '0;
        for (int i = 0; i < 3; i++) begin
            if (dvs[i] != 8'd0) begin
                quot[i] = dvd[i] / dvs[i];
                rem[i]  = dvd[i] % dvs[i];
            end
        end
    end
    assign dbz = force_dbz | {dvs[2] == 8'd0, dvs[1] == 8'd0, dvs[0] == 8'd0};

    radix_digit_extractor #(.RADIX(10), .DIGITS(3)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_value(in_value[0]), .div_dividend(dvd[0]), .div_divisor(dvs[0]),
        .div_quotient(quot[0]), .div_remainder(rem[0]), .div_by_zero(dbz[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .digits(dg_a),
        .overflow(ovf[0]), .error(err[0]));

    radix_digit_extractor #(.RADIX(10), .DIGITS(2)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_value(in_value[1]), .div_dividend(dvd[1]), .div_divisor(dvs[1]),
        .div_quotient(quot[1]), .div_remainder(rem[1]), .div_by_zero(dbz[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .digits(dg_b),
        .overflow(ovf[1]), .error(err[1]));

    radix_digit_extractor #(.RADIX(2), .DIGITS(8)) u_dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_value(in_value[2]), .div_dividend(dvd[2]), .div_divisor(dvs[2]),
        .div_quotient(quot[2]), .div_remainder(rem[2]), .div_by_zero(dbz[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .digits(dg_c),
        .overflow(ovf[2]), .error(err[2]));

    function automatic logic [31:0] get_dg(input int k);
        case (k)
            0:       return {20'd0, dg_a};
            1:       return {24'd0, dg_b};
            default: return dg_c;
        endcase
    endfunction

    // Cycles from accept edge to first out_valid.
    function automatic int exp_lat(input int v, input int radix, input int nd);
`ifdef RADIX_DIGIT_EXTRACTOR_EARLY_EXIT_EN
        int n = 1;
        int q = v / radix;
        while (q != 0 && n < nd) begin
            n++;
            q = q / radix;
        end
        return n;
`else
        return nd;
`endif
    endfunction

    // One full conversion on instance k; called at a falling edge with k idle.
    task automatic run(input int k, input logic [7:0] v, output logic [31:0] dg,
                       output int lat, output logic ov, output logic er);
        in_valid[k] = 1'b1;
        in_value[k] = v;
        @(negedge clk);
        in_valid[k] = 1'b0;
        lat = 0;
        while (!out_valid[k] && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (out_valid[k] !== 1'b1) begin
            bad++;
            $display("FAIL timeout inst%0d value=%0d: out_valid=%b want 1", k, v, out_valid[k]);
        end
        dg = get_dg(k);
        ov = ovf[k];
        er = err[k];
        out_ready[k] = 1'b1;
        @(negedge clk);
        out_ready[k] = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++; if (in_ready[k] !== 1'b1) begin bad++; $display("FAIL reset_in_ready%0d got=%b want=1", k, in_ready[k]); end
            total++; if (out_valid[k] !== 1'b0) begin bad++; $display("FAIL reset_out_valid%0d got=%b want=0", k, out_valid[k]); end
            total++; if (get_dg(k) !== 32'd0) begin bad++; $display("FAIL reset_digits%0d got=%h want=0", k, get_dg(k)); end
            total++; if ({ovf[k], err[k]} !== 2'b00) begin bad++; $display("FAIL reset_flags%0d got=%b want=00", k, {ovf[k], err[k]}); end
        end
        total++; if (dvs[0] !== 8'd10) begin bad++; $display("FAIL divisor_a got=%0d want=10", dvs[0]); end
        total++; if (dvs[2] !== 8'd2) begin bad++; $display("FAIL divisor_c got=%0d want=2", dvs[2]); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_decimal();
        logic [31:0] dg; int lat; logic ov, er;
        logic [7:0]  vals [3]  = '{8'd123, 8'd0, 8'd255};
        logic [31:0] wants [3] = '{32'h123, 32'h000, 32'h255};
        for (int i = 0; i < 3; i++) begin
            run(0, vals[i], dg, lat, ov, er);
            total++; if (dg !== wants[i]) begin bad++; $display("FAIL dec_digits v=%0d got=%h want=%h", vals[i], dg, wants[i]); end
            total++; if (lat !== exp_lat(vals[i], 10, 3)) begin bad++; $display("FAIL dec_latency v=%0d got=%0d want=%0d", vals[i], lat, exp_lat(vals[i], 10, 3)); end
            total++; if ({ov, er} !== 2'b00) begin bad++; $display("FAIL dec_flags v=%0d got=%b want=00", vals[i], {ov, er}); end
        end
    endtask

    task automatic test_overflow();
        logic [31:0] dg; int lat; logic ov, er;
        logic [7:0]  vals [3]  = '{8'd255, 8'd0, 8'd7};
        logic [31:0] wants [3] = '{32'h55, 32'h00, 32'h07};
        logic        ovs [3]   = '{1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 3; i++) begin
            run(1, vals[i], dg, lat, ov, er);
            total++; if (dg !== wants[i]) begin bad++; $display("FAIL ovf_digits v=%0d got=%h want=%h", vals[i], dg, wants[i]); end
            total++; if (ov !== ovs[i]) begin bad++; $display("FAIL ovf_flag v=%0d got=%b want=%b", vals[i], ov, ovs[i]); end
            total++; if (lat !== exp_lat(vals[i], 10, 2)) begin bad++; $display("FAIL ovf_latency v=%0d got=%0d want=%0d", vals[i], lat, exp_lat(vals[i], 10, 2)); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] dg; int lat; logic ov, er;
        int wait_cnt = 0;
        in_valid[0] = 1'b1;
        in_value[0] = 8'd42;
        @(negedge clk);
        in_valid[0] = 1'b0;
        while (!out_valid[0] && wait_cnt < 40) begin
            @(negedge clk);
            wait_cnt++;
        end
        in_valid[0] = 1'b1;
        in_value[0] = 8'd99;
        for (int c = 0; c < 5; c++) begin
            total++; if (out_valid[0] !== 1'b1) begin bad++; $display("FAIL bp_out_valid c=%0d got=%b want=1", c, out_valid[0]); end
            total++; if (dg_a !== 12'h042) begin bad++; $display("FAIL bp_digits c=%0d got=%h want=042", c, dg_a); end
            total++; if (in_ready[0] !== 1'b0) begin bad++; $display("FAIL bp_in_ready c=%0d got=%b want=0", c, in_ready[0]); end
            @(negedge clk);
        end
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        total++; if ({in_ready[0], out_valid[0]} !== 2'b10) begin bad++; $display("FAIL bp_release got=%b want=10", {in_ready[0], out_valid[0]}); end
        run(0, 8'd99, dg, lat, ov, er);
        total++; if (dg !== 32'h099) begin bad++; $display("FAIL bp_next_digits got=%h want=099", dg); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] dg; int lat; logic ov, er;
        in_valid[0] = 1'b1;
        in_value[0] = 8'd200;
        @(negedge clk);
        in_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        total++; if ({in_ready[0], out_valid[0]} !== 2'b10) begin bad++; $display("FAIL mid_rst_hs got=%b want=10", {in_ready[0], out_valid[0]}); end
        total++; if (dg_a !== 12'h000) begin bad++; $display("FAIL mid_rst_digits got=%h want=000", dg_a); end
        total++; if (dvd[0] !== 8'd0) begin bad++; $display("FAIL mid_rst_work got=%0d want=0", dvd[0]); end
        run(0, 8'd45, dg, lat, ov, er);
        total++; if (dg !== 32'h045) begin bad++; $display("FAIL mid_rst_next got=%h want=045", dg); end
    endtask

    task automatic test_radix2();
        logic [31:0] dg; int lat; logic ov, er;
        run(2, 8'hA5, dg, lat, ov, er);
        total++; if (dg !== 32'h10100101) begin bad++; $display("FAIL bin_digits_a5 got=%h want=10100101", dg); end
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL bin_ovf_a5 got=%b want=0", ov); end
        total++; if (lat !== exp_lat(8'hA5, 2, 8)) begin bad++; $display("FAIL bin_latency got=%0d want=%0d", lat, exp_lat(8'hA5, 2, 8)); end
        run(2, 8'h12, dg, lat, ov, er);
        total++; if (dg !== 32'h00010010) begin bad++; $display("FAIL bin_digits_12 got=%h want=00010010", dg); end
    endtask

    task automatic test_div_by_zero();
        logic [31:0] dg; int lat; logic ov, er;
        in_valid[0] = 1'b1;
        in_value[0] = 8'd123;
        @(negedge clk);
        in_valid[0]  = 1'b0;
        force_dbz[0] = 1'b1;
        @(negedge clk);
        force_dbz[0] = 1'b0;
        total++; if (out_valid[0] !== 1'b1) begin bad++; $display("FAIL dbz_out_valid got=%b want=1", out_valid[0]); end
        total++; if (err[0] !== 1'b1) begin bad++; $display("FAIL dbz_error got=%b want=1", err[0]); end
        total++; if ({dg_a, ovf[0]} !== 13'd0) begin bad++; $display("FAIL dbz_clear got=%h/%b want=000/0", dg_a, ovf[0]); end
        out_ready[0] = 1'b1;
        @(negedge clk);
        out_ready[0] = 1'b0;
        run(0, 8'd9, dg, lat, ov, er);
        total++; if ({dg, er} !== {32'h009, 1'b0}) begin bad++; $display("FAIL dbz_recover got=%h/%b want=009/0", dg, er); end
    endtask

    task automatic test_back_to_back();
        int rises [2];
        int n = 0;
        logic prev = 1'b0;
        int want = exp_lat(5, 10, 3) + 2;
        in_valid[0]  = 1'b1;
        in_value[0]  = 8'd5;
        out_ready[0] = 1'b1;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (out_valid[0] && !prev && n < 2) begin
                rises[n] = c;
                n++;
            end
            prev = out_valid[0];
        end
        in_valid[0] = 1'b0;
        repeat (6) @(negedge clk);
        out_ready[0] = 1'b0;
        total++;
        if (n !== 2) begin
            bad++;
            $display("FAIL b2b_count got=%0d want=2", n);
        end else if (rises[1] - rises[0] !== want) begin
            bad++;
            $display("FAIL b2b_period got=%0d want=%0d", rises[1] - rises[0], want);
        end
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = '0;
        in_value  = '0;
        out_ready = '0;
        force_dbz = '0;
        test_reset();
        test_decimal();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_radix2();
        test_div_by_zero();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
